// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared types and defaults for the elastic filter pipeline.
// Revision : 1.0
// ============================================================================
package fp_pkg;

   localparam int BIT_VEC_SIZE = 8;
   localparam int SEL_MAX_W    = 8;

   typedef enum logic [2:0] {
      OP_PASS   = 3'd0,
      OP_AND_M  = 3'd1,
      OP_OR_M   = 3'd2,
      OP_XOR_M  = 3'd3,
      OP_AND_P  = 3'd4,
      OP_OR_P   = 3'd5,
      OP_ANDN_P = 3'd6,
      OP_KILL   = 3'd7
   } fp_op_e;

   typedef enum logic [0:0] {
      CMT_IDLE    = 1'b0,
      CMT_PENDING = 1'b1
   } fp_cmt_e;

   typedef logic [BIT_VEC_SIZE-1:0] fp_vec_t;
   typedef logic [SEL_MAX_W-1:0]    fp_sel_t;

   typedef struct packed {
      fp_sel_t sel;
      fp_op_e  op;
      fp_vec_t mask;
   } fp_cfg_t;

   localparam fp_op_e FP_OP_DEFAULT = OP_PASS;

   // Mask ops keep the lane's own valid; partner ops need both lanes valid.
   function automatic logic fp_lane_valid(fp_op_e op, logic pv, logic qv);
      case (op)
         OP_PASS, OP_AND_M, OP_OR_M, OP_XOR_M: return pv;
         OP_AND_P, OP_OR_P, OP_ANDN_P:         return pv & qv;
         default:                              return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_stage.sv
`default_nettype none
// ============================================================================
// Module   : fp_stage
// Purpose  : One permute + per-lane filter stage with an elastic output slice.
// Revision : 1.0
// ============================================================================
module fp_stage
   import fp_pkg::*;
#(
   parameter int LANES = 4,
   parameter int W     = BIT_VEC_SIZE
)
(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_valid,
   input  logic [LANES-1:0]                      i_lane_vld,
   input  logic [LANES-1:0][W-1:0]               i_data,
   output logic                                  o_ready,
   input  logic                                  i_next_ready,
   output logic                                  o_valid,
   output logic [LANES-1:0]                      o_lane_vld,
   output logic [LANES-1:0][W-1:0]               o_data,
   input  logic [LANES-1:0][$clog2(LANES)-1:0]   i_sel,
   input  logic [LANES-1:0][2:0]                 i_op,
   input  logic [LANES-1:0][W-1:0]               i_mask
);

   logic [LANES-1:0][W-1:0] w_p;
   logic [LANES-1:0][W-1:0] w_res;
   logic [LANES-1:0]        w_pv;
   logic [LANES-1:0]        w_rv;

   logic                    r_occ;
   logic [LANES-1:0]        r_lv;
   logic [LANES-1:0][W-1:0] r_dat;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      localparam int PJ = j ^ 1;
      fp_op_e      w_op;
      logic [W-1:0] w_r;

      assign w_p[j]  = i_data[i_sel[j]];
      assign w_pv[j] = i_lane_vld[i_sel[j]];
      assign w_op    = fp_op_e'(i_op[j]);

      always_comb begin
         w_r = '0;
         case (w_op)
            OP_PASS:   w_r = w_p[j];
            OP_AND_M:  w_r = w_p[j] & i_mask[j];
            OP_OR_M:   w_r = w_p[j] | i_mask[j];
            OP_XOR_M:  w_r = w_p[j] ^ i_mask[j];
            OP_AND_P:  w_r = w_p[j] & w_p[PJ];
            OP_OR_P:   w_r = w_p[j] | w_p[PJ];
            OP_ANDN_P: w_r = w_p[j] & ~w_p[PJ];
            default:   w_r = '0;
         endcase
      end

      assign w_rv[j]  = fp_lane_valid(w_op, w_pv[j], w_pv[PJ]);
      assign w_res[j] = w_rv[j] ? w_r : '0;
   end

   // An empty slot always accepts, which lets bubbles collapse under a stall.
   assign o_ready = !r_occ | i_next_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ <= 1'b0;
         r_lv  <= '0;
         r_dat <= '0;
      end else if (o_ready) begin
         r_occ <= i_valid;
         if (i_valid) begin
            r_lv  <= w_rv;
            r_dat <= w_res;
         end
      end
   end

   assign o_valid    = r_occ;
   assign o_lane_vld = r_lv;
   assign o_data     = r_dat;

endmodule
`default_nettype wire

// File: rtl/fp_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_elastic_pipe
// Purpose  : Elastic multi-stage lane filter with double-buffered configuration.
// Revision : 1.0
// ============================================================================
module fp_elastic_pipe
   import fp_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int STAGES = 4,
   parameter int W      = BIT_VEC_SIZE,
   localparam int LW    = $clog2(LANES),
   localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_in_valid,
   input  logic [LANES-1:0]     i_in_lane_vld,
   input  logic [W-1:0]         i_in_data [LANES],
   output logic                 o_in_ready,
   output logic                 o_out_valid,
   output logic [LANES-1:0]     o_out_lane_vld,
   output logic [W-1:0]         o_out_data [LANES],
   input  logic                 i_out_ready,
   input  logic                 i_cfg_we,
   input  logic [SW-1:0]        i_cfg_stage,
   input  logic [LW-1:0]        i_cfg_lane,
   input  logic [LW-1:0]        i_cfg_sel,
   input  logic [2:0]           i_cfg_op,
   input  logic [W-1:0]         i_cfg_mask,
   input  logic                 i_cfg_commit,
   output logic                 o_cfg_busy
);

   logic [STAGES-1:0][LANES-1:0][LW-1:0] r_act_sel;
   logic [STAGES-1:0][LANES-1:0][2:0]    r_act_op;
   logic [STAGES-1:0][LANES-1:0][W-1:0]  r_act_msk;
   logic [STAGES-1:0][LANES-1:0][LW-1:0] r_shd_sel;
   logic [STAGES-1:0][LANES-1:0][2:0]    r_shd_op;
   logic [STAGES-1:0][LANES-1:0][W-1:0]  r_shd_msk;
   fp_cmt_e                              r_state;
   logic                                 r_busy;

   logic [STAGES:0]                      w_vld;
   logic [STAGES:0]                      w_rdy;
   logic [LANES-1:0]                     w_lv  [STAGES+1];
   logic [LANES-1:0][W-1:0]              w_dat [STAGES+1];
   logic [STAGES-1:0]                    w_occ;

   // Inputs are held off while a commit waits for the pipe to drain.
   assign w_vld[0]      = i_in_valid & !r_busy;
   assign w_lv[0]       = i_in_lane_vld;
   assign w_rdy[STAGES] = i_out_ready;
   assign w_occ         = w_vld[STAGES:1];

   assign o_in_ready     = w_rdy[0] & !r_busy & !rst;
   assign o_out_valid    = w_vld[STAGES];
   assign o_out_lane_vld = w_lv[STAGES];
   assign o_cfg_busy     = r_busy;

   for (genvar j = 0; j < LANES; j++) begin : g_lane_io
      assign w_dat[0][j]   = i_in_data[j];
      assign o_out_data[j] = w_dat[STAGES][j];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      fp_stage #(
         .LANES (LANES),
         .W     (W)
      ) u_stage (
         .clk          (clk),
         .rst          (rst),
         .i_valid      (w_vld[k]),
         .i_lane_vld   (w_lv[k]),
         .i_data       (w_dat[k]),
         .o_ready      (w_rdy[k]),
         .i_next_ready (w_rdy[k+1]),
         .o_valid      (w_vld[k+1]),
         .o_lane_vld   (w_lv[k+1]),
         .o_data       (w_dat[k+1]),
         .i_sel        (r_act_sel[k]),
         .i_op         (r_act_op[k]),
         .i_mask       (r_act_msk[k])
      );
   end

   // The bank copy reads the shadow before this edge's write lands in it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CMT_IDLE;
         r_busy  <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            for (int j = 0; j < LANES; j++) begin
               r_act_sel[k][j] <= LW'(j);
               r_act_op[k][j]  <= FP_OP_DEFAULT;
               r_act_msk[k][j] <= '1;
               r_shd_sel[k][j] <= LW'(j);
               r_shd_op[k][j]  <= FP_OP_DEFAULT;
               r_shd_msk[k][j] <= '1;
            end
         end
      end else begin
         case (r_state)
            CMT_IDLE: begin
               if (i_cfg_commit) begin
                  r_state <= CMT_PENDING;
                  r_busy  <= 1'b1;
               end
            end
            CMT_PENDING: begin
               if (w_occ == '0) begin
                  r_state   <= CMT_IDLE;
                  r_busy    <= 1'b0;
                  r_act_sel <= r_shd_sel;
                  r_act_op  <= r_shd_op;
                  r_act_msk <= r_shd_msk;
               end
            end
            default: begin
               r_state <= CMT_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         for (int k = 0; k < STAGES; k++) begin
            for (int j = 0; j < LANES; j++) begin
               if (i_cfg_we && i_cfg_stage == SW'(k) && i_cfg_lane == LW'(j)) begin
                  r_shd_sel[k][j] <= i_cfg_sel;
                  r_shd_op[k][j]  <= i_cfg_op;
                  r_shd_msk[k][j] <= i_cfg_mask;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire
